// File: rtl/adc_readout_sched_pkg.sv
// Shared constants, FSM state encoding and a small index helper for the
// ADC readout scheduler.
package adc_readout_pkg;

  localparam int DEF_NUM_CHANNELS = 8;
  localparam int DEF_DATA_WIDTH   = 12;
  localparam int DEF_CH_WIDTH     = $clog2(DEF_NUM_CHANNELS);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_PRESENT = 2'd3
  } adc_state_e;

  // Channel index reached by stepping 'offset' positions past 'base', wrapping at n.
  function automatic int rr_wrap(input int base, input int offset, input int n);
    return (base + offset) % n;
  endfunction

endpackage

// File: rtl/adc_readout_sched_if.sv
// FIFO read bus plus downstream valid/ready sample stream. The scheduler
// uses the master view; the FIFO bank / sink side uses the slave view.
interface adc_readout_sched_if #(
  parameter int NUM_CHANNELS = adc_readout_pkg::DEF_NUM_CHANNELS,
  parameter int DATA_WIDTH   = adc_readout_pkg::DEF_DATA_WIDTH
);
  import adc_readout_pkg::*;

  localparam int CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

  logic [NUM_CHANNELS-1:0]                 fifo_not_empty;
  logic [NUM_CHANNELS-1:0]                 fifo_full;
  logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] fifo_dout;
  logic [NUM_CHANNELS-1:0]                 fifo_rd_en;
  logic [DATA_WIDTH-1:0]                   out_data;
  logic [CH_W-1:0]                         out_ch;
  logic                                    out_valid;
  logic                                    out_ready;

  modport master (
    input  fifo_not_empty, fifo_full, fifo_dout, out_ready,
    output fifo_rd_en, out_data, out_ch, out_valid
  );

  modport slave (
    output fifo_not_empty, fifo_full, fifo_dout, out_ready,
    input  fifo_rd_en, out_data, out_ch, out_valid
  );

endinterface

// File: rtl/adc_readout_sched_rr_arbiter.sv
// Round-robin picker: the search starts one past the last granted channel
// and wraps, so every requesting channel is served within NUM_CHANNELS grants.
module rr_arbiter
  import adc_readout_pkg::*;
#(
  parameter int NUM_CHANNELS = DEF_NUM_CHANNELS,
  parameter int CH_W         = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic [NUM_CHANNELS-1:0] i_req,
  input  logic [CH_W-1:0]         i_last_grant,
  output logic [NUM_CHANNELS-1:0] o_grant,
  output logic [CH_W-1:0]         o_grant_idx,
  output logic                    o_any_req
);

  logic [CH_W-1:0] w_cand;
  logic            w_found;

  // Walk the channels in priority order and keep the first requester seen.
  always_comb begin
    o_grant     = {NUM_CHANNELS{1'b0}};
    o_grant_idx = {CH_W{1'b0}};
    w_found     = 1'b0;
    w_cand      = {CH_W{1'b0}};
    for (int k = 1; k <= NUM_CHANNELS; k++) begin
      w_cand = CH_W'(rr_wrap(int'(i_last_grant), k, NUM_CHANNELS));
      if (!w_found && i_req[w_cand]) begin
        w_found         = 1'b1;
        o_grant[w_cand] = 1'b1;
        o_grant_idx     = w_cand;
      end else begin
        w_found = w_found;
      end
    end
  end

  assign o_any_req = |i_req;

endmodule

// File: rtl/adc_readout_sched.sv
// ADC readout scheduler: round-robin drains per-channel sample FIFOs into a
// single valid/ready stream, one word in flight at a time, and keeps sticky
// per-channel overflow flags.
module adc_readout_sched
  import adc_readout_pkg::*;
#(
  parameter int NUM_CHANNELS = DEF_NUM_CHANNELS,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    enable,
  input  logic [NUM_CHANNELS-1:0] chan_mask,
  input  logic                    ovf_clear,
  output logic [NUM_CHANNELS-1:0] ovf_flags,
  adc_readout_sched_if.master     bus
);

  localparam int              CH_W    = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CHANNELS - 1);

  adc_state_e              r_state;
  logic [CH_W-1:0]         r_last_grant;
  logic [DATA_WIDTH-1:0]   r_out_data;
  logic [CH_W-1:0]         r_out_ch;
  logic                    r_out_valid;
  logic [NUM_CHANNELS-1:0] r_ovf_flags;

  logic [NUM_CHANNELS-1:0] w_req;
  logic [NUM_CHANNELS-1:0] w_grant;
  logic [CH_W-1:0]         w_grant_idx;
  logic                    w_any_req;
  logic                    w_start;

  // Mask is applied live, so a mask change only influences the next grant.
  assign w_req   = bus.fifo_not_empty & chan_mask;
  assign w_start = enable & w_any_req;

  rr_arbiter #(
    .NUM_CHANNELS (NUM_CHANNELS),
    .CH_W         (CH_W)
  ) u_rr_arbiter (
    .i_req        (w_req),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant),
    .o_grant_idx  (w_grant_idx),
    .o_any_req    (w_any_req)
  );

  // The grant is evaluated against this cycle's not-empty flags, so a strobe
  // can never hit an empty FIFO; an empty request vector yields no strobe.
  assign bus.fifo_rd_en = (r_state == ST_ISSUE) ? w_grant : {NUM_CHANNELS{1'b0}};

  // Sequencer: grant and read, capture the FIFO word, hold it until accepted.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= ST_IDLE;
      r_last_grant <= LAST_CH;
      r_out_data   <= {DATA_WIDTH{1'b0}};
      r_out_ch     <= {CH_W{1'b0}};
      r_out_valid  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) r_state <= ST_ISSUE;
          else         r_state <= ST_IDLE;
        end
        ST_ISSUE: begin
          // Once in ISSUE the read is committed; enable is not re-checked.
          if (w_any_req) begin
            r_last_grant <= w_grant_idx;
            r_state      <= ST_CAPTURE;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_CAPTURE: begin
          r_out_data  <= bus.fifo_dout[r_last_grant];
          r_out_ch    <= r_last_grant;
          r_out_valid <= 1'b1;
          r_state     <= ST_PRESENT;
        end
        ST_PRESENT: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= w_start ? ST_ISSUE : ST_IDLE;
          end else begin
            r_state <= ST_PRESENT;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  // Sticky overflow flags; a full indication in the same cycle as a clear wins.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ovf_flags <= {NUM_CHANNELS{1'b0}};
    end else begin
      r_ovf_flags <= (r_ovf_flags & ~{NUM_CHANNELS{ovf_clear}}) | bus.fifo_full;
    end
  end

  assign bus.out_data  = r_out_data;
  assign bus.out_ch    = r_out_ch;
  assign bus.out_valid = r_out_valid;
  assign ovf_flags     = r_ovf_flags;

endmodule

// File: tb/tb_adc_readout_sched.sv
// Self-checking bench for adc_readout_sched: directed scenarios followed by
// randomized traffic, all checked against a transaction-level reference.
module tb_adc_readout_sched;
  import adc_readout_pkg::*;

  localparam int NCH = DEF_NUM_CHANNELS;
  localparam int DW  = DEF_DATA_WIDTH;
  localparam int CW  = $clog2(NCH);

  logic           clk = 1'b0;
  logic           rstn;
  logic           enable;
  logic [NCH-1:0] chan_mask;
  logic           ovf_clear;
  logic [NCH-1:0] ovf_flags;

  adc_readout_sched_if bus ();

  adc_readout_sched dut (
    .clk       (clk),
    .rstn      (rstn),
    .enable    (enable),
    .chan_mask (chan_mask),
    .ovf_clear (ovf_clear),
    .ovf_flags (ovf_flags),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference arbitration: first requester after 'last', wrapping; -1 if none.
  function automatic int rr_pick(input logic [NCH-1:0] req, input int last);
    int c;
    for (int k = 1; k <= NCH; k++) begin
      c = (last + k) % NCH;
      if (((req >> c) & NCH'(1)) != '0) return c;
    end
    return -1;
  endfunction

  // Reference state (owned by the monitor)
  int             exp_ch[$];
  logic [DW-1:0]  exp_dat[$];
  int             m_last = NCH - 1;
  logic [NCH-1:0] m_ovf = '0;
  logic [NCH-1:0] req_prev = '0;
  bit             free_prev = 1'b1;
  bit             en_prev = 1'b0;
  bit             prev_valid = 1'b0;
  bit             prev_xfer = 1'b0;
  logic [DW-1:0]  held_data = '0;
  logic [CW-1:0]  held_ch = '0;
  int             cyc = 0;
  int             issue_cyc = 0;
  bit             force_en = 1'b0;
  logic [DW-1:0]  force_val = '0;

  // Monitor: FIFO data source plus scoreboard, evaluated mid-cycle.
  initial begin : monitor
    logic [NCH-1:0] req_now;
    logic [NCH-1:0] exp_rd;
    logic [DW-1:0]  dat;
    logic [CW-1:0]  gi;
    int             g;
    bit             xfer;
    forever begin
      @(negedge clk);
      cyc++;
      req_now = bus.fifo_not_empty & chan_mask;
      if (rstn !== 1'b1) begin
        exp_ch.delete();
        exp_dat.delete();
        m_last        = NCH - 1;
        m_ovf         = '0;
        free_prev     = 1'b1;
        en_prev       = 1'b0;
        req_prev      = '0;
        prev_valid    = 1'b0;
        prev_xfer     = 1'b0;
        bus.fifo_dout = '0;
      end else begin
        check_eq("ovf_flags", ovf_flags, m_ovf);
        if (prev_valid && !prev_xfer) begin
          check_eq("hold_valid", bus.out_valid, 1'b1);
          check_eq("hold_data", bus.out_data, held_data);
          check_eq("hold_ch", bus.out_ch, held_ch);
        end
        if (bus.out_valid && !prev_valid) check_eq("latency", cyc - issue_cyc, 2);
        if (free_prev)
          check_eq("issue_start", bus.fifo_rd_en != '0,
                   en_prev && (req_prev != '0) && (req_now != '0));
        if (bus.fifo_rd_en != '0) begin
          g      = rr_pick(req_now, m_last);
          exp_rd = (g < 0) ? '0 : (NCH'(1) << g);
          check_eq("grant", bus.fifo_rd_en, exp_rd);
          check_eq("one_in_flight", exp_ch.size(), 0);
          if (g >= 0) begin
            gi  = CW'(g);
            dat = force_en ? force_val : DW'($urandom);
            bus.fifo_dout[gi] = dat;
            exp_ch.push_back(g);
            exp_dat.push_back(dat);
            m_last    = g;
            issue_cyc = cyc;
          end
        end
        xfer = bus.out_valid && bus.out_ready;
        if (xfer) begin
          check_eq("xfer_expected", exp_ch.size() != 0, 1'b1);
          if (exp_ch.size() != 0) begin
            check_eq("out_ch", bus.out_ch, exp_ch.pop_front());
            check_eq("out_data", bus.out_data, exp_dat.pop_front());
          end
        end
        m_ovf      = (m_ovf & ~{NCH{ovf_clear}}) | bus.fifo_full;
        free_prev  = (exp_ch.size() == 0);
        en_prev    = enable;
        req_prev   = req_now;
        prev_valid = bus.out_valid;
        prev_xfer  = xfer;
        held_data  = bus.out_data;
        held_ch    = bus.out_ch;
      end
    end
  end

  task automatic apply_reset();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  task automatic wait_valid(input string tag, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.out_valid !== 1'b1 && n < 60);
    check_eq({tag, "_valid"}, bus.out_valid, 1'b1);
  endtask

  task automatic wait_rd(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.fifo_rd_en == '0 && n < 60);
    check_eq({tag, "_strobe"}, bus.fifo_rd_en != '0, 1'b1);
  endtask

  initial begin : stimulus
    int            n;
    logic [DW-1:0] hd;
    logic [CW-1:0] hc;
    rstn               = 1'b0;
    enable             = 1'b0;
    chan_mask          = 8'hFF;
    ovf_clear          = 1'b0;
    bus.fifo_not_empty = '0;
    bus.fifo_full      = '0;
    bus.out_ready      = 1'b0;

    // Reset state
    #12;
    check_eq("rst_valid", bus.out_valid, 1'b0);
    check_eq("rst_data", bus.out_data, 12'h000);
    check_eq("rst_ch", bus.out_ch, 3'd0);
    check_eq("rst_rd_en", bus.fifo_rd_en, 8'h00);
    check_eq("rst_ovf", ovf_flags, 8'h00);
    @(posedge clk);
    #1 rstn = 1'b1;

    // Single channel 3 with a known word
    enable = 1'b1; chan_mask = 8'hFF; bus.fifo_not_empty = 8'h08;
    force_en = 1'b1; force_val = 12'h5A5;
    wait_rd("t_single");
    check_eq("single_rd", bus.fifo_rd_en, 8'h08);
    @(negedge clk);
    check_eq("single_rd_off", bus.fifo_rd_en, 8'h00);
    check_eq("single_not_yet", bus.out_valid, 1'b0);
    @(negedge clk);
    check_eq("single_valid", bus.out_valid, 1'b1);
    check_eq("single_data", bus.out_data, 12'h5A5);
    check_eq("single_ch", bus.out_ch, 3'd3);
    @(posedge clk);
    #1 bus.fifo_not_empty = 8'h00; bus.out_ready = 1'b1; force_en = 1'b0;

    // All channels busy: full rotation including wrap, one word per 3 cycles
    apply_reset();
    bus.fifo_not_empty = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      wait_valid("t_rot", n);
      check_eq("rot_ch", bus.out_ch, i % NCH);
      if (i > 0) check_eq("rot_gap", n, 3);
    end

    // Downstream stall: held output, no reads, then resume with next channel
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    wait_valid("t_stall", n);
    hd = bus.out_data;
    hc = bus.out_ch;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("stall_data", bus.out_data, hd);
      check_eq("stall_ch", bus.out_ch, hc);
      check_eq("stall_rd", bus.fifo_rd_en, 8'h00);
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_eq("stall_next", bus.fifo_rd_en, NCH'(1) << ((int'(hc) + 1) % NCH));

    // Mask 0x21 alternation, then enable dropped while capturing
    chan_mask = 8'h21;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      wait_valid("t_mask", n);
      check_eq("mask_ch", bus.out_ch, (i % 2 == 0) ? 3'd0 : 3'd5);
    end
    wait_rd("t_endrop");
    @(posedge clk);
    #1 enable = 1'b0;
    wait_valid("t_endrop", n);
    check_eq("endrop_ch", bus.out_ch, 3'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_eq("endrop_idle", bus.fifo_rd_en, 8'h00);
    end

    // Sticky overflow flag and set-beats-clear
    @(posedge clk);
    #1 bus.fifo_full = 8'h40;
    @(posedge clk);
    #1 bus.fifo_full = 8'h00;
    repeat (4) @(negedge clk);
    check_eq("ovf_sticky", ovf_flags, 8'h40);
    @(posedge clk);
    #1 ovf_clear = 1'b1;
    @(posedge clk);
    #1 ovf_clear = 1'b0;
    @(negedge clk);
    check_eq("ovf_cleared", ovf_flags, 8'h00);
    @(posedge clk);
    #1 ovf_clear = 1'b1; bus.fifo_full = 8'h40;
    @(posedge clk);
    #1 ovf_clear = 1'b0; bus.fifo_full = 8'h00;
    @(negedge clk);
    check_eq("ovf_set_wins", ovf_flags, 8'h40);

    // Reset asserted in CAPTURE
    @(posedge clk);
    #1 enable = 1'b1; chan_mask = 8'hFF; bus.fifo_not_empty = 8'hFF;
    wait_rd("t_rstcap");
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    check_eq("rstcap_valid", bus.out_valid, 1'b0);
    check_eq("rstcap_data", bus.out_data, 12'h000);
    check_eq("rstcap_ch", bus.out_ch, 3'd0);
    check_eq("rstcap_rd", bus.fifo_rd_en, 8'h00);
    check_eq("rstcap_ovf", ovf_flags, 8'h00);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    check_eq("rstcap_first_cyc", bus.fifo_rd_en, 8'h00);
    wait_rd("t_rstcap2");
    check_eq("rstcap_grant0", bus.fifo_rd_en, 8'h01);

    // Randomized traffic against the scoreboard
    for (int c = 0; c < 2500; c++) begin
      @(posedge clk);
      #1;
      enable = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 39) == 0) chan_mask = NCH'($urandom);
      bus.fifo_not_empty = NCH'($urandom);
      bus.out_ready      = ($urandom_range(0, 3) != 0);
      bus.fifo_full      = ($urandom_range(0, 15) == 0) ? NCH'($urandom) : '0;
      ovf_clear          = ($urandom_range(0, 24) == 0);
    end
    @(posedge clk);
    #1 enable = 1'b0; bus.out_ready = 1'b1; bus.fifo_full = '0; ovf_clear = 1'b0;
    repeat (20) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/adc_readout_sched.md
ADC_READOUT_SCHED -- requirements
Module: adc_readout_sched

Interface
REQ-001 Parameter NUM_CHANNELS, default 8, is the number of per-channel sample FIFOs served.
REQ-002 Parameter DATA_WIDTH, default 12, is the sample width from each FIFO.
REQ-003 Port clk, input, 1: single clock (65 MHz); all FIFO read ports are clocked by clk.
REQ-004 Port rstn, input, 1: asynchronous, active-low reset.
REQ-005 Port enable, input, 1: when high, the scheduler starts new reads.
REQ-006 Port chan_mask, input, NUM_CHANNELS: bit i high means channel i is eligible.
REQ-007 Port fifo_not_empty, input, NUM_CHANNELS: per-channel FIFO holds at least one word.
REQ-008 Port fifo_full, input, NUM_CHANNELS: per-channel FIFO full.
REQ-009 Port fifo_dout, input, NUM_CHANNELS x DATA_WIDTH: per-channel FIFO read data, valid one cycle after rd_en.
REQ-010 Port fifo_rd_en, output, NUM_CHANNELS: one-hot read strobe.
REQ-011 Port out_data, output, DATA_WIDTH: sample presented downstream.
REQ-012 Port out_ch, output, $clog2(NUM_CHANNELS): source channel of out_data.
REQ-013 Port out_valid, output, 1; out_ready, input, 1: valid/ready handshake.
REQ-014 Port ovf_flags, output, NUM_CHANNELS: sticky per-channel full indication; ovf_clear, input, 1: clears ovf_flags.

Function
REQ-015 FSM states IDLE, ISSUE, CAPTURE, PRESENT.
REQ-016 Request vector req = fifo_not_empty & chan_mask; IDLE -> ISSUE when enable high and req non-zero.
REQ-017 ISSUE lasts one cycle: fifo_rd_en[g] high for exactly that cycle, g = granted channel; -> CAPTURE.
REQ-018 CAPTURE: register fifo_dout[g] into out_data and g into out_ch, set out_valid next cycle; -> PRESENT.
REQ-019 PRESENT: out_data/out_ch/out_valid held stable until out_valid & out_ready; transfer clears out_valid.
REQ-020 On transfer: -> ISSUE same cycle if enable and req non-zero (next grant computed combinationally), else -> IDLE; sustained rate 1 word per 3 cycles.
REQ-021 Grant is round-robin: search starts at (last_grant+1) mod NUM_CHANNELS, first set bit of req wins; last_grant updates in ISSUE.
REQ-022 fifo_rd_en never asserted for a channel whose fifo_not_empty is low in that cycle.
REQ-023 enable low mid-transaction: the word already read completes ISSUE/CAPTURE/PRESENT and is delivered; no further ISSUE.
REQ-024 chan_mask changes take effect at the next grant only; an in-flight word is never dropped.
REQ-025 ovf_flags[i] sets on any cycle fifo_full[i] is high; ovf_clear clears all bits; simultaneous set and clear on a bit: set wins.
REQ-026 Wrap-around: after grant to channel NUM_CHANNELS-1 the search continues from channel 0.

Reset
REQ-027 rstn low asynchronously forces state IDLE, fifo_rd_en 0, out_valid 0, out_data 0, out_ch 0, ovf_flags 0, last_grant NUM_CHANNELS-1 (so channel 0 has first priority).
REQ-028 Reset mid-transaction discards the in-flight word; no read strobe is issued in the first cycle after rstn rises.

Structure
REQ-029 Package adc_readout_pkg holds NUM_CHANNELS, DATA_WIDTH, channel-index width and the FSM state enum.
REQ-030 Round-robin selection is a sub-module rr_arbiter (req, last_grant in; one-hot grant, index, any_req out).

Verification
REQ-031 Reset, enable=1, mask=0xFF, only ch3 non-empty with dout=0x5A5 -> fifo_rd_en=0x08 one cycle, out_valid two cycles later with out_data=0x5A5, out_ch=3.
REQ-032 All channels non-empty, out_ready=1 -> out_ch sequence 0,1,2,...,7,0; each fifo_rd_en one-hot; word every 3 cycles.
REQ-033 out_ready=0 for 10 cycles in PRESENT -> out_data/out_ch stable, no fifo_rd_en; after ready high, transfer then next grant.
REQ-034 mask=0x21, all non-empty -> out_ch alternates 0,5,0,5; enable dropped in CAPTURE -> that word delivered, then IDLE.
REQ-035 fifo_full[6] pulse one cycle -> ovf_flags=0x40 persists; ovf_clear coincident with fifo_full[6] -> bit stays set.
REQ-036 rstn asserted in CAPTURE -> all outputs 0 immediately; after release, first grant is channel 0 if non-empty.
